gb_rd_data_buf: RTL and testbench

//  Downstream return stage of the GB read controller; one instance per read stream (WeiFlg/Act/ActFlg).

---
 rtl/gb_rd_data_buf.sv | 140 ++++++++++++++
 tb/tb_gb_rd_data_buf.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_rd_data_buf.sv
// gb_rd_data_buf
//   Return stage of the GB read controller, one instance per read stream.
//   A read issued with read_en carries an absolute bank ID. One cycle later
//   that bank's word is picked off the flattened SRAM read bus and written
//   into a small circular queue. The queue head is presented to the PE array.
//   rd_stall back-pressures the read controller so it never overruns the queue.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous clear; wins over every other input
//   read_en       SRAM read issued this cycle
//   rd_id         absolute bank ID of that read
//   sram_rdata    all banks' read data, valid one cycle after read_en
//   rd_stall      read controller must not assert read_en next cycle
//   PE_rdy        PE accepts the head word
//   PE_val        PE_data holds a queued word
//   PE_data       head-of-queue word
//   occupancy     queued entries plus the in-flight read
//   err_overflow  sticky: a read arrived with no free slot
//   err_bad_id    sticky: a read ID at or beyond NUM_BANK was captured
//
// Handshake: a word moves to the PE on every rising edge where
// PE_val = 1 and PE_rdy = 1. PE_val never depends on PE_rdy in the same
// cycle. While PE_val = 1 and PE_rdy = 0, PE_data is held stable.
module gb_rd_data_buf #(
    parameter int DATA_WIDTH = 96,
    parameter int NUM_BANK   = 32,
    parameter int ID_WIDTH   = 6,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           read_en,
    input  logic [ID_WIDTH-1:0]            rd_id,
    input  logic [NUM_BANK*DATA_WIDTH-1:0] sram_rdata,
    output logic                           rd_stall,
    input  logic                           PE_rdy,
    output logic                           PE_val,
    output logic [DATA_WIDTH-1:0]          PE_data,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic                           err_overflow,
    output logic                           err_bad_id
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]       FULL     = CW'(DEPTH);
    localparam logic [ID_WIDTH:0]   NB_LIMIT = (ID_WIDTH + 1)'(NUM_BANK);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic                  inflight_v;
    logic [ID_WIDTH-1:0]   inflight_id;

    logic                  pop;
    logic                  push;
    logic                  id_bad;
    logic [DATA_WIDTH-1:0] sel_word;
    logic [CW:0]           occ_next_read;

    // Bank select for the in-flight read. An ID with no matching bank
    // leaves the word at zero, which is what a bad ID must deliver.
    always_comb begin
        sel_word = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if ({1'b0, inflight_id} == (ID_WIDTH + 1)'(b)) begin
                sel_word = sram_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign id_bad = ({1'b0, inflight_id} >= NB_LIMIT);

    assign PE_val    = (count != '0);
    assign PE_data   = mem[rptr];
    assign pop       = PE_val & PE_rdy;
    // A pop on the same edge frees the head slot, so a write into a full
    // queue is still legal when the PE takes a word at the same time.
    assign push      = inflight_v & ((count < FULL) | pop);
    assign occupancy = count + CW'(inflight_v);

    // Counts the read issued this cycle, so a controller that obeys
    // rd_stall always finds a slot when its data lands.
    assign occ_next_read = {1'b0, occupancy} + {{CW{1'b0}}, read_en};
    assign rd_stall      = (occ_next_read >= {1'b0, FULL});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            inflight_v   <= 1'b0;
            inflight_id  <= '0;
            err_overflow <= 1'b0;
            err_bad_id   <= 1'b0;
        end else if (flush) begin
            // Drops queued and in-flight data; the read issued in this
            // cycle is ignored. Error flags survive until rst_n.
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            inflight_v <= 1'b0;
        end else begin
            inflight_v <= read_en;
            if (read_en) begin
                inflight_id <= rd_id;
            end

            if (push) begin
                mem[wptr] <= sel_word;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // No slot will exist for this read when it lands. Also covers
            // an occupancy already past DEPTH from an earlier forced read.
            if (read_en && (occupancy >= FULL) && !pop) begin
                err_overflow <= 1'b1;
            end
            if (inflight_v && id_bad) begin
                err_bad_id <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gb_rd_data_buf.sv
module tb_gb_rd_data_buf;

  localparam int DW    = 96;
  localparam int NB    = 32;
  localparam int IW    = 6;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               flush;
  logic               read_en;
  logic [IW-1:0]      rd_id;
  logic [NB*DW-1:0]   sram_rdata;
  logic               rd_stall;
  logic               pe_rdy;
  logic               pe_val;
  logic [DW-1:0]      pe_data;
  logic [OW-1:0]      occupancy;
  logic               err_overflow;
  logic               err_bad_id;

  gb_rd_data_buf #(
    .DATA_WIDTH (DW),
    .NUM_BANK   (NB),
    .ID_WIDTH   (IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .read_en      (read_en),
    .rd_id        (rd_id),
    .sram_rdata   (sram_rdata),
    .rd_stall     (rd_stall),
    .PE_rdy       (pe_rdy),
    .PE_val       (pe_val),
    .PE_data      (pe_data),
    .occupancy    (occupancy),
    .err_overflow (err_overflow),
    .err_bad_id   (err_bad_id)
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word held by bank b; IDs outside the bus read as zero.
  function automatic logic [DW-1:0] bank_word(input int b);
    if (b >= NB) return '0;
    return {24'hA5A5A5, 8'(b), 32'h0101_0101 * 32'(b), 32'hC0DE_0000 | 32'(b)};
  endfunction

  // driver tasks: inputs change and outputs are sampled 2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_read(input logic en, input int id);
    read_en = en;
    rd_id   = IW'(id);
  endtask

  // Pop expected words while the DUT presents them, within a cycle budget.
  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    set_read(1'b0, 0);
    pe_rdy = 1'b1;
    #1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (pe_val) check(tag, pe_data, exp_q.pop_front());
      tick();
      cyc++;
    end
    check({tag, "_left"}, DW'(exp_q.size()), DW'(0));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int recv;
    int cyc;
    logic stall_q;
    logic exp_stall [6];
    exp_stall = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    for (int b = 0; b < NB; b++) sram_rdata[b*DW +: DW] = bank_word(b);
    rst_n = 1'b0;
    flush = 1'b0;
    pe_rdy = 1'b0;
    set_read(1'b0, 0);

    // ---- reset state ----
    tick(); tick();
    check("rst_pe_val",  DW'(pe_val), DW'(0));
    check("rst_pe_data", pe_data, DW'(0));
    check("rst_occ",     DW'(occupancy), DW'(0));
    check("rst_stall",   DW'(rd_stall), DW'(0));
    check("rst_err_ovf", DW'(err_overflow), DW'(0));
    check("rst_err_bad", DW'(err_bad_id), DW'(0));
    rst_n = 1'b1;
    tick();

    // ---- single read, bank 5, latency 2, one beat ----
    pe_rdy = 1'b1;
    set_read(1'b1, 5);
    tick();
    set_read(1'b0, 0);
    check("single_occ_t1", DW'(occupancy), DW'(1));
    check("single_val_t1", DW'(pe_val), DW'(0));
    tick();
    check("single_val_t2",  DW'(pe_val), DW'(1));
    check("single_data_t2", pe_data, bank_word(5));
    tick();
    check("single_val_t3", DW'(pe_val), DW'(0));
    check("single_occ_t3", DW'(occupancy), DW'(0));

    // ---- 8 reads honoring rd_stall, PE stalled then draining ----
    pe_rdy = 1'b0;
    stall_q = 1'b0;
    issued = 0;
    for (int c = 0; c < 6; c++) begin
      set_read((issued < 8) && !stall_q, 10 + issued);
      #1;
      check("fill_stall", DW'(rd_stall), DW'(exp_stall[c]));
      stall_q = rd_stall;
      if (read_en) begin
        exp_q.push_back(bank_word(10 + issued));
        issued++;
      end
      tick();
    end
    check("fill_issued",  DW'(issued), DW'(4));
    check("fill_occ",     DW'(occupancy), DW'(4));
    check("fill_head",    pe_data, bank_word(10));
    pe_rdy = 1'b1;
    recv = 0;
    cyc = 0;
    while ((issued < 8 || exp_q.size() > 0) && cyc < 40) begin
      set_read((issued < 8) && !stall_q, 10 + issued);
      #1;
      if (pe_val) begin
        if (exp_q.size() == 0) check("b2b_extra_beat", DW'(1), DW'(0));
        else check("b2b_order", pe_data, exp_q.pop_front());
        recv++;
      end
      stall_q = rd_stall;
      if (read_en) begin
        exp_q.push_back(bank_word(10 + issued));
        issued++;
      end
      tick();
      cyc++;
    end
    set_read(1'b0, 0);
    check("b2b_recv",    DW'(recv), DW'(8));
    check("b2b_err_ovf", DW'(err_overflow), DW'(0));
    tick();
    check("b2b_empty", DW'(pe_val), DW'(0));
    exp_q.delete();

    // ---- forced read into a full queue ----
    pe_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_read(1'b1, 20 + i);
      exp_q.push_back(bank_word(20 + i));
      tick();
    end
    set_read(1'b0, 0);
    tick();
    #1;
    check("full_occ",     DW'(occupancy), DW'(4));
    check("full_stall",   DW'(rd_stall), DW'(1));
    check("full_err_ovf", DW'(err_overflow), DW'(0));
    set_read(1'b1, 24);
    tick();
    set_read(1'b0, 0);
    check("ovf_flag", DW'(err_overflow), DW'(1));
    check("ovf_occ",  DW'(occupancy), DW'(5));
    tick();
    check("ovf_occ_after", DW'(occupancy), DW'(4));
    check("ovf_head",      pe_data, bank_word(20));
    check("ovf_sticky",    DW'(err_overflow), DW'(1));

    // ---- push+pop at count=DEPTH over 3 wraps ----
    set_read(1'b1, 25);
    exp_q.push_back(bank_word(25));
    tick();
    pe_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_read(1'b1, k);
      #1;
      check("wrap_occ", DW'(occupancy), DW'(5));
      check("wrap_val", DW'(pe_val), DW'(1));
      check("wrap_data", pe_data, exp_q.pop_front());
      exp_q.push_back(bank_word(k));
      tick();
    end
    drain("wrap_drain", 20);
    check("wrap_final_val", DW'(pe_val), DW'(0));
    check("wrap_final_occ", DW'(occupancy), DW'(0));

    // ---- flush with 3 queued + 1 in flight + read_en ----
    pe_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_read(1'b1, i);
      tick();
    end
    check("pre_flush_occ", DW'(occupancy), DW'(4));
    flush = 1'b1;
    set_read(1'b1, 6);
    tick();
    flush = 1'b0;
    set_read(1'b0, 0);
    check("flush_val", DW'(pe_val), DW'(0));
    check("flush_occ", DW'(occupancy), DW'(0));
    tick(); tick(); tick();
    check("flush_val_later", DW'(pe_val), DW'(0));
    check("flush_occ_later", DW'(occupancy), DW'(0));
    check("flush_keeps_err", DW'(err_overflow), DW'(1));
    pe_rdy = 1'b1;
    set_read(1'b1, 7);
    tick();
    set_read(1'b0, 0);
    tick();
    check("post_flush_val",  DW'(pe_val), DW'(1));
    check("post_flush_data", pe_data, bank_word(7));
    tick();

    // ---- bad ID delivers a zero word ----
    set_read(1'b1, 40);
    tick();
    set_read(1'b0, 0);
    check("bad_id_flag_t1", DW'(err_bad_id), DW'(0));
    tick();
    check("bad_id_val",  DW'(pe_val), DW'(1));
    check("bad_id_data", pe_data, DW'(0));
    check("bad_id_flag", DW'(err_bad_id), DW'(1));
    tick();
    check("bad_id_popped", DW'(pe_val), DW'(0));

    // ---- async reset mid-stream ----
    pe_rdy = 1'b0;
    set_read(1'b1, 8);
    tick();
    set_read(1'b1, 9);
    tick();
    set_read(1'b0, 0);
    check("pre_rst_occ", DW'(occupancy), DW'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_val",     DW'(pe_val), DW'(0));
    check("arst_data",    pe_data, DW'(0));
    check("arst_occ",     DW'(occupancy), DW'(0));
    check("arst_stall",   DW'(rd_stall), DW'(0));
    check("arst_err_ovf", DW'(err_overflow), DW'(0));
    check("arst_err_bad", DW'(err_bad_id), DW'(0));
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_val", DW'(pe_val), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
